// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per cycle, N = WIDTH/DIGIT cycles from the accept edge to the done pulse.
// Accepts start only while idle (no queuing); subtract support is built only when DIGIT_SERIAL_ADDER_SUB_EN is defined.
`timescale 1ns/1ps

module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             overflow
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic               sub_eff;
   logic [DIGIT-1:0]   a_dig, b_dig, dig_sum;
   logic [DIGIT:0]     dig_full;
   logic               dig_cout, c_into_msb;
   logic [WIDTH-1:0]   acc_next;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   assign sub_eff = sub;
`else
   logic sub_unused;
   assign sub_unused = sub;
   assign sub_eff    = 1'b0;
`endif

   // Operands shift right one digit per cycle, so the live digit is always the low one.
   always_comb begin
      a_dig      = a_q[DIGIT-1:0];
      b_dig      = b_q[DIGIT-1:0];
      dig_full   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
      dig_sum    = dig_full[DIGIT-1:0];
      dig_cout   = dig_full[DIGIT];
      c_into_msb = dig_sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
      acc_next   = (acc_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = sub_eff ? ~B : B;
               carry_d = Cin ^ sub_eff;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dig_cout;
            acc_d   = acc_next;
            if (cnt_q == LAST) begin
               sum_d   = acc_next;
               cout_d  = dig_cout;
               ovf_d   = c_into_msb ^ dig_cout;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign Sum      = sum_q;
   assign Cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: default 16/4 instance plus 8/8 and 32/1 parameter sweeps.
`timescale 1ns/1ps

module tb_digit_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        cin = 1'b0, sub = 1'b0;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        cin8 = 1'b0, sub8 = 1'b0;
   logic        busy8, done8, cout8, ovf8;
   logic [7:0]  sum8;

   logic        start32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        cin32 = 1'b0, sub32 = 1'b0;
   logic        busy32, done32, cout32, ovf32;
   logic [31:0] sum32;

   int          checks = 0;
   int          errors = 0;
   int          lat;
   int          ndone;
   logic [15:0] prev_sum = '0;
   logic [8:0]  ref8;
   logic [32:0] ref32;
   logic        rovf;

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin), .sub(sub),
      .busy(busy), .done(done), .Sum(sum), .Cout(cout), .overflow(ovf)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8), .sub(sub8),
      .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8), .overflow(ovf8)
   );

   digit_serial_adder #(.WIDTH(32), .DIGIT(1)) u_dut32 (
      .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32), .Cin(cin32), .sub(sub32),
      .busy(busy32), .done(done32), .Sum(sum32), .Cout(cout32), .overflow(ovf32)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input logic sv, input string tag);
      a     = av;
      b     = bv;
      cin   = cv;
      sub   = sv;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
   endtask

   // Waits for done with a bounded cycle budget; Sum must hold its old value until then.
   task automatic wait_done(input string tag, input logic [15:0] es,
                            input logic ec, input logic eo);
      int l = 0;
      do begin
         tick();
         l++;
         if (!done) chk({tag, "_hold"}, 64'(sum), 64'(prev_sum));
      end while (!done && l < 40);
      chk({tag, "_lat"}, 64'(l), 64'd4);
      chk({tag, "_sum"}, 64'(sum), 64'(es));
      chk({tag, "_cout"}, 64'(cout), 64'(ec));
      chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
      chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
      prev_sum = es;
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);

      start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, "basic");
      wait_done("basic", 16'h0100, 1'b0, 1'b0);
      tick();
      chk("basic_done_pulse", 64'(done), 64'd0);

      start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "carry_all");
      wait_done("carry_all", 16'h0000, 1'b1, 1'b0);
      start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "sovf");
      wait_done("sovf", 16'h8000, 1'b0, 1'b1);
      start_op(16'h1234, 16'h4321, 1'b1, 1'b0, "cin");
      wait_done("cin", 16'h5556, 1'b0, 1'b0);

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      start_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub");
      wait_done("sub", 16'hFFFE, 1'b0, 1'b0);
`else
      start_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_off");
      wait_done("sub_off", 16'h000C, 1'b0, 1'b0);
`endif
      sub = 1'b0;

      // start held high through busy, operand changed mid-op: one result from latched operands
      a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
      tick();
      chk("hold_busy0", 64'(busy), 64'd1);
      a = 16'h0100;
      repeat (3) begin
         tick();
         chk("hold_busy", 64'(busy), 64'd1);
         chk("hold_nodone", 64'(done), 64'd0);
      end
      start = 1'b0;
      tick();
      chk("hold_done", 64'(done), 64'd1);
      chk("hold_sum", 64'(sum), 64'h0003);
      prev_sum = 16'h0003;
      ndone = 0;
      repeat (6) begin
         tick();
         if (done) ndone++;
      end
      chk("hold_extra_done", 64'(ndone), 64'd0);
      chk("hold_idle", 64'(busy), 64'd0);

      start_op(16'h0010, 16'h0020, 1'b0, 1'b0, "b2b_first");
      wait_done("b2b_first", 16'h0030, 1'b0, 1'b0);
      start_op(16'h1234, 16'h1111, 1'b0, 1'b0, "b2b_second");
      wait_done("b2b_second", 16'h2345, 1'b0, 1'b0);

      start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "abort");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      chk("abort_ovf", 64'(ovf), 64'd0);
      prev_sum = '0;
      ndone = 0;
      repeat (6) begin
         tick();
         if (done) ndone++;
      end
      chk("abort_no_done", 64'(ndone), 64'd0);
      start_op(16'h0002, 16'h0003, 1'b0, 1'b0, "after_abort");
      wait_done("after_abort", 16'h0005, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
         end else begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
         end
         ref8 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
         rovf = (a8[7] == b8[7]) && (ref8[7] != a8[7]);
         start8 = 1'b1;
         tick();
         start8 = 1'b0;
         lat = 0;
         do begin
            tick();
            lat++;
         end while (!done8 && lat < 10);
         chk("w8_lat", 64'(lat), 64'd1);
         chk("w8_sum", 64'(sum8), 64'(ref8[7:0]));
         chk("w8_cout", 64'(cout8), 64'(ref8[8]));
         chk("w8_ovf", 64'(ovf8), 64'(rovf));
      end

      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0000; cin32 = 1'b1;
         end else begin
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1));
         end
         ref32 = {1'b0, a32} + {1'b0, b32} + {32'd0, cin32};
         rovf = (a32[31] == b32[31]) && (ref32[31] != a32[31]);
         start32 = 1'b1;
         tick();
         start32 = 1'b0;
         lat = 0;
         do begin
            tick();
            lat++;
         end while (!done32 && lat < 80);
         chk("w32_lat", 64'(lat), 64'd32);
         chk("w32_sum", 64'(sum32), 64'(ref32[31:0]));
         chk("w32_cout", 64'(cout32), 64'(ref32[32]));
         chk("w32_ovf", 64'(ovf32), 64'(rovf));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
